// File: rtl/usb_pkg.sv
// Shared constants and state type for the USB full-speed transmit path.
package usb_pkg;

    localparam logic [1:0] PKT_NONE  = 2'b00;
    localparam logic [1:0] PKT_DATA0 = 2'b01;
    localparam logic [1:0] PKT_NAK   = 2'b10;
    localparam logic [1:0] PKT_ACK   = 2'b11;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic [6:0] MAX_PAYLOAD = 7'd64;

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J
    } tx_state_t;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) r[i] = v[15 - i];
        return r;
    endfunction

    function automatic logic [7:0] pid_for(input logic [1:0] pkt);
        case (pkt)
            PKT_ACK:   return PID_ACK;
            PKT_NAK:   return PID_NAK;
            default:   return PID_DATA0;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16, LSB-first (shift-right form of polynomial 0x8005).
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    localparam logic [15:0] POLY_REF = reflect16(CRC_POLY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= CRC_INIT;
        else if (clear)
            crc <= CRC_INIT;
        else if (enable)
            crc <= (crc >> 1) ^ ((crc[0] ^ bit_in) ? POLY_REF : '0);
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed handshake/DATA0 transmitter: SYNC, PID, payload, CRC16,
// bit stuffing, NRZI line coding and EOP generation.
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] TX_Packet,
    input  logic [6:0] TX_Packet_Data_Size,
    input  logic [7:0] TX_Packet_Data,
    output logic       Get_TX_Packet_Data,
    output logic       Dplus_Out,
    output logic       Dminus_Out,
    output logic       TX_Done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    tx_state_t     state, nstate;
    logic [1:0]    pkt;
    logic [6:0]    bytes_left, pulses_left;
    logic [2:0]    bit_idx, nidx, ones;
    logic [TW-1:0] timer;
    logic [7:0]    cur_byte, next_byte, data_byte, pid_byte;
    logic          get_d, line_j, nbit, stuff, last, boundary;
    logic          crc_en, crc_clr;
    logic [15:0]   crc;
    logic [6:0]    req_size;

    usb_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clr),
        .enable (crc_en),
        .bit_in (nbit),
        .crc    (crc)
    );

    // state/bit_idx describe the bit currently on the line; the comb block
    // picks what goes out at the next bit boundary.
    always_comb begin
        stuff    = (ones == 3'd6) && (state inside {SYNC, PID, DATA, CRC_LO, CRC_HI});
        last     = (bit_idx == 3'd7);
        nstate   = state;
        nidx     = bit_idx + 3'd1;
        pid_byte = pid_for(pkt);
        req_size = (TX_Packet_Data_Size > MAX_PAYLOAD) ? MAX_PAYLOAD : TX_Packet_Data_Size;
        case (state)
            SYNC:    if (last) nstate = PID;
            PID:     if (last) nstate = (pkt != PKT_DATA0) ? EOP_SE0 :
                                        (bytes_left != '0) ? DATA : CRC_LO;
            DATA:    if (last) nstate = (bytes_left == '0) ? CRC_LO : DATA;
            CRC_LO:  if (last) nstate = CRC_HI;
            CRC_HI:  if (last) nstate = EOP_SE0;
            EOP_SE0: if (bit_idx == 3'd1) begin
                         nstate = EOP_J;
                         nidx   = '0;
                     end
            default: nstate = IDLE;
        endcase
        data_byte = (nidx == 3'd0) ? next_byte : cur_byte;
        case (nstate)
            SYNC:    nbit = SYNC_BYTE[nidx];
            PID:     nbit = pid_byte[nidx];
            DATA:    nbit = data_byte[nidx];
            CRC_LO:  nbit = ~crc[{1'b0, nidx}];
            CRC_HI:  nbit = ~crc[{1'b1, nidx}];
            default: nbit = 1'b1;
        endcase
        boundary = (state != IDLE) && (timer == LAST_TICK);
        crc_en   = boundary && !stuff && (nstate == DATA);
        crc_clr  = (state == IDLE) && (TX_Packet != PKT_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            pkt                <= PKT_NONE;
            bytes_left         <= '0;
            pulses_left        <= '0;
            bit_idx            <= '0;
            ones               <= '0;
            timer              <= '0;
            cur_byte           <= '0;
            next_byte          <= '0;
            get_d              <= 1'b0;
            line_j             <= 1'b1;
            Get_TX_Packet_Data <= 1'b0;
            Dplus_Out          <= 1'b1;
            Dminus_Out         <= 1'b0;
            TX_Done            <= 1'b0;
        end else begin
            get_d              <= Get_TX_Packet_Data;
            Get_TX_Packet_Data <= 1'b0;
            if (get_d) next_byte <= TX_Packet_Data;
            if (state == IDLE) begin
                TX_Done <= 1'b0;
                timer   <= '0;
                if (TX_Packet != PKT_NONE) begin
                    // First SYNC bit goes out immediately, coded from idle J.
                    pkt        <= TX_Packet;
                    bytes_left <= req_size;
                    state      <= SYNC;
                    bit_idx    <= '0;
                    ones       <= '0;
                    line_j     <= SYNC_BYTE[0];
                    Dplus_Out  <= SYNC_BYTE[0];
                    Dminus_Out <= ~SYNC_BYTE[0];
                end
            end else begin
                timer   <= timer + TW'(1);
                TX_Done <= (state == EOP_J) && (int'(timer) == CLKS_PER_BIT - 2);
                if (boundary) begin
                    timer <= '0;
                    if (state == EOP_J) begin
                        state   <= IDLE;
                        TX_Done <= 1'b0;
                    end else if (stuff) begin
                        ones       <= '0;
                        line_j     <= ~line_j;
                        Dplus_Out  <= ~line_j;
                        Dminus_Out <= line_j;
                    end else begin
                        state   <= nstate;
                        bit_idx <= nidx;
                        if (nstate == EOP_SE0) begin
                            ones       <= '0;
                            Dplus_Out  <= 1'b0;
                            Dminus_Out <= 1'b0;
                        end else if (nstate == EOP_J) begin
                            line_j     <= 1'b1;
                            Dplus_Out  <= 1'b1;
                            Dminus_Out <= 1'b0;
                            TX_Done    <= (CLKS_PER_BIT == 1);
                        end else begin
                            ones       <= nbit ? ones + 3'd1 : '0;
                            line_j     <= nbit ? line_j : ~line_j;
                            Dplus_Out  <= nbit ? line_j : ~line_j;
                            Dminus_Out <= nbit ? ~line_j : line_j;
                        end
                        // Each byte fetch is issued a full byte ahead of its use.
                        if (nstate == PID && nidx == 3'd0 && pkt == PKT_DATA0 &&
                            bytes_left != '0) begin
                            Get_TX_Packet_Data <= 1'b1;
                            pulses_left        <= bytes_left - 7'd1;
                        end
                        if (nstate == DATA && nidx == 3'd0) begin
                            cur_byte   <= next_byte;
                            bytes_left <= bytes_left - 7'd1;
                            if (pulses_left != '0) begin
                                Get_TX_Packet_Data <= 1'b1;
                                pulses_left        <= pulses_left - 7'd1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Randomized bench for usb_tx_encoder against a bit-stream reference model.
module tb_usb_tx_encoder;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] TX_Packet;
    logic [6:0] TX_Packet_Data_Size;
    logic [7:0] TX_Packet_Data;
    logic       Get_TX_Packet_Data;
    logic       Dplus_Out;
    logic       Dminus_Out;
    logic       TX_Done;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned gidx   = 0;
    logic [7:0]  payload [64];
    logic [1:0]  exp_line [$];

    always #5 clk = ~clk;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .TX_Packet           (TX_Packet),
        .TX_Packet_Data_Size (TX_Packet_Data_Size),
        .TX_Packet_Data      (TX_Packet_Data),
        .Get_TX_Packet_Data  (Get_TX_Packet_Data),
        .Dplus_Out           (Dplus_Out),
        .Dminus_Out          (Dminus_Out),
        .TX_Done             (TX_Done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Data buffer: a byte appears mid-cycle of the request and stays valid
    // through the following cycle.
    initial begin
        TX_Packet_Data = '0;
        forever begin
            @(negedge clk);
            if (Get_TX_Packet_Data === 1'b1) begin
                if (gidx < 64) TX_Packet_Data = payload[gidx];
                gidx++;
            end
        end
    end

    // Expected per-cycle {D+,D-} for a whole packet, built from the bit stream.
    task automatic build_expected(input logic [1:0] pkt, input int unsigned n);
        bit          bits[$];
        bit          stuffed[$];
        logic [7:0]  sync_b, pid, byte_v;
        logic [15:0] crc;
        bit          fb;
        int unsigned ones;
        logic        lvl;
        sync_b = 8'h80;
        pid = (pkt == 2'b11) ? 8'hD2 : (pkt == 2'b10) ? 8'h5A : 8'hC3;
        for (int unsigned i = 0; i < 8; i++) bits.push_back(sync_b[i]);
        for (int unsigned i = 0; i < 8; i++) bits.push_back(pid[i]);
        if (pkt == 2'b01) begin
            crc = 16'hFFFF;
            for (int unsigned b = 0; b < n; b++) begin
                byte_v = payload[b];
                for (int unsigned i = 0; i < 8; i++) begin
                    bits.push_back(byte_v[i]);
                    fb  = crc[15] ^ byte_v[i];
                    crc = {crc[14:0], 1'b0};
                    if (fb) crc = crc ^ 16'h8005;
                end
            end
            for (int unsigned i = 16; i > 0; i--) bits.push_back(~crc[i-1]);
        end
        ones = 0;
        foreach (bits[i]) begin
            stuffed.push_back(bits[i]);
            ones = bits[i] ? ones + 1 : 0;
            if (ones == 6) begin
                stuffed.push_back(1'b0);
                ones = 0;
            end
        end
        exp_line.delete();
        lvl = 1'b1;
        foreach (stuffed[i]) begin
            if (!stuffed[i]) lvl = ~lvl;
            repeat (CPB) exp_line.push_back({lvl, ~lvl});
        end
        repeat (2 * CPB) exp_line.push_back(2'b00);
        repeat (CPB) exp_line.push_back(2'b10);
    endtask

    // Caller drives from a negedge; the request is accepted on the next posedge.
    task automatic send_packet(input logic [1:0] pkt, input int unsigned size, input bit poke);
        int unsigned n, total;
        n = (pkt == 2'b01) ? ((size > 64) ? 64 : size) : 0;
        build_expected(pkt, n);
        gidx = 0;
        TX_Packet = pkt;
        TX_Packet_Data_Size = 7'(size);
        @(posedge clk); #1;
        TX_Packet = poke ? 2'($urandom_range(1, 3)) : 2'b00;
        total = exp_line.size();
        for (int unsigned k = 0; k < total; k++) begin
            if (k == 40) TX_Packet = 2'b00;
            check_eq("line", {30'b0, Dplus_Out, Dminus_Out}, {30'b0, exp_line[k]});
            check_eq("done", {31'b0, TX_Done}, {31'b0, (k == total - 1)});
            @(posedge clk); #1;
        end
        check_eq("idle_line", {30'b0, Dplus_Out, Dminus_Out}, 32'h2);
        check_eq("idle_done", {31'b0, TX_Done}, 32'h0);
        check_eq("get_count", gidx, n);
    endtask

    task automatic fill_random();
        for (int unsigned i = 0; i < 64; i++) payload[i] = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        TX_Packet = 2'b11;
        TX_Packet_Data_Size = '0;
        for (int unsigned i = 0; i < 64; i++) payload[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_line", {30'b0, Dplus_Out, Dminus_Out}, 32'h2);
        check_eq("rst_done", {31'b0, TX_Done}, 32'h0);
        check_eq("rst_get", {31'b0, Get_TX_Packet_Data}, 32'h0);

        @(negedge clk); rst = 1'b0;
        send_packet(2'b11, 0, 1'b0);
        @(negedge clk); send_packet(2'b10, 0, 1'b1);
        @(negedge clk); send_packet(2'b01, 0, 1'b0);
        payload[0] = 8'hFF;
        @(negedge clk); send_packet(2'b01, 1, 1'b0);
        fill_random();
        @(negedge clk); send_packet(2'b01, 64, 1'b0);
        for (int unsigned t = 0; t < 3; t++) begin
            fill_random();
            @(negedge clk); send_packet(2'b01, $urandom_range(1, 64), 1'($urandom));
        end
        fill_random();
        @(negedge clk); send_packet(2'b01, 100, 1'b0);

        // Abort a DATA0 packet mid-payload while an ACK request is held.
        fill_random();
        @(negedge clk);
        TX_Packet = 2'b01;
        TX_Packet_Data_Size = 7'd8;
        @(posedge clk); #1;
        TX_Packet = 2'b11;
        repeat (100) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("abort_line", {30'b0, Dplus_Out, Dminus_Out}, 32'h2);
        check_eq("abort_done", {31'b0, TX_Done}, 32'h0);
        check_eq("abort_get", {31'b0, Get_TX_Packet_Data}, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("hold_line", {30'b0, Dplus_Out, Dminus_Out}, 32'h2);
            check_eq("hold_done", {31'b0, TX_Done}, 32'h0);
        end
        @(negedge clk); rst = 1'b0;
        send_packet(2'b11, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
